// File: rtl/datapath_pkg.sv
// Shared types and constants for the registered ALU datapath.
// Optional signed-overflow output is enabled with DATAPATH_OVF_EN.
package datapath_pkg;

    localparam int DATAPATH_N = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_PASS = 3'b111
    } opcode_e;

    function automatic logic is_arith(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Purely combinational operation logic for the datapath.
// With DATAPATH_OVF_EN defined, a signed overflow output is also produced.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int N = DATAPATH_N
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
`ifdef DATAPATH_OVF_EN
    output logic         overflow,
`endif
    output logic [N-1:0] result,
    output logic         carry
);

    opcode_e      op;
    logic [N:0]   sum_ext;
    logic [N:0]   diff_ext;
    logic         add_ovf;
    logic         sub_ovf;

    assign op = opcode_e'(opcode);

    // Zero-extended arithmetic: bit N is the unsigned carry (add) or borrow (sub).
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    assign add_ovf = (A[N-1] == B[N-1]) && (sum_ext[N-1]  != A[N-1]);
    assign sub_ovf = (A[N-1] != B[N-1]) && (diff_ext[N-1] != A[N-1]);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_ext[N-1:0];
                carry  = sum_ext[N];
            end
            OP_SUB: begin
                result = diff_ext[N-1:0];
                carry  = diff_ext[N];
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_SHL: begin
                result = {A[N-2:0], 1'b0};
                carry  = A[N-1];
            end
            OP_ASR: begin
                result = {A[N-1], A[N-1:1]};
                carry  = A[0];
            end
            OP_PASS: result = B;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

`ifdef DATAPATH_OVF_EN
    always_comb begin
        overflow = 1'b0;
        if (is_arith(op)) begin
            overflow = (op == OP_ADD) ? add_ovf : sub_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = add_ovf ^ sub_ovf;
`endif

endmodule

// File: rtl/datapath.sv
// Registered ALU datapath: one-cycle latency, results held while in_valid is low.
// Define DATAPATH_OVF_EN to add the registered signed-overflow output ovf.
module datapath
    import datapath_pkg::*;
#(
    parameter int N = DATAPATH_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    input  logic         in_valid,
    output logic [N-1:0] Y,
    output logic         co,
`ifdef DATAPATH_OVF_EN
    output logic         ovf,
`endif
    output logic         out_valid
);

    logic [N-1:0] alu_result;
    logic         alu_carry;

    logic [N-1:0] y_d,     y_q;
    logic         co_d,    co_q;
    logic         valid_d, valid_q;

`ifdef DATAPATH_OVF_EN
    logic         alu_ovf;
    logic         ovf_d,   ovf_q;
`endif

    datapath_alu #(
        .N (N)
    ) u_alu (
        .A        (A),
        .B        (B),
        .opcode   (opcode),
`ifdef DATAPATH_OVF_EN
        .overflow (alu_ovf),
`endif
        .result   (alu_result),
        .carry    (alu_carry)
    );

    // Results are only loaded on a capture; otherwise the last result is held.
    always_comb begin
        y_d     = y_q;
        co_d    = co_q;
        valid_d = in_valid;
        if (in_valid) begin
            y_d  = alu_result;
            co_d = alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            co_q    <= co_d;
            valid_q <= valid_d;
        end
    end

`ifdef DATAPATH_OVF_EN
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign Y         = y_q;
    assign co        = co_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_datapath.sv
// Directed, table-driven self-checking bench for datapath at N=16.
// Build with DATAPATH_OVF_EN defined to also check the ovf output.
module tb_datapath;
    import datapath_pkg::*;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [2:0]   op_in;
    logic         in_valid;
    logic [N-1:0] y_out;
    logic         co_out;
    logic         valid_out;
`ifdef DATAPATH_OVF_EN
    logic         ovf_out;
`endif

    int checks;
    int failures;

    datapath #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a_in),
        .B         (b_in),
        .opcode    (op_in),
        .in_valid  (in_valid),
        .Y         (y_out),
        .co        (co_out),
`ifdef DATAPATH_OVF_EN
        .ovf       (ovf_out),
`endif
        .out_valid (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_y;
        logic         exp_co;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic v);
        op_in    = op;
        a_in     = a;
        b_in     = b;
        in_valid = v;
    endtask

    task automatic check_output(input string name, input logic [N-1:0] ey, input logic eco, input logic eovf, input logic ev);
        check({name, ".Y"}, 64'(y_out), 64'(ey));
        check({name, ".co"}, 64'(co_out), 64'(eco));
        check({name, ".out_valid"}, 64'(valid_out), 64'(ev));
`ifdef DATAPATH_OVF_EN
        check({name, ".ovf"}, 64'(ovf_out), 64'(eovf));
`else
        if (eovf === 1'bx) $display("[TB] unexpected unknown ovf expectation in %s", name);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};
        vecs[3]  = '{OP_SUB,  16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0};
        vecs[4]  = '{OP_SHL,  16'h8001, 16'h1234, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{OP_ASR,  16'hFFFC, 16'h5555, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{OP_AND,  16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0};
        vecs[7]  = '{OP_OR,   16'h0F0F, 16'h00FF, 16'h0FFF, 1'b0, 1'b0};
        vecs[8]  = '{OP_XOR,  16'h0F0F, 16'h00FF, 16'h0FF0, 1'b0, 1'b0};
        vecs[9]  = '{OP_PASS, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0};
        vecs[10] = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[11] = '{OP_ASR,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{OP_SHL,  16'h4000, 16'hFFFF, 16'h8000, 1'b0, 1'b0};
        vecs[13] = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[14] = '{OP_SUB,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        apply_stimulus(OP_ADD, 16'h0003, 16'h0004, 1'b1);
        #1;
        check_output("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("reset_clocked", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Release reset away from the edge with in_valid low: no capture yet.
        apply_stimulus(OP_PASS, 16'h0000, 16'h0055, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back vectors: each one is captured at the next edge.
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            tick();
            check_output($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_co, vecs[i].exp_ovf, 1'b1);
        end

        // Hold: in_valid low with changing inputs keeps the last result.
        apply_stimulus(OP_ADD, 16'h7FFF, 16'h7FFF, 1'b1);
        tick();
        check_output("hold_setup", 16'hFFFE, 1'b0, 1'b1, 1'b1);
        apply_stimulus(OP_SUB, 16'h0001, 16'h0002, 1'b0);
        tick();
        check_output("hold_1", 16'hFFFE, 1'b0, 1'b1, 1'b0);
        apply_stimulus(OP_XOR, 16'hAAAA, 16'h5555, 1'b0);
        tick();
        check_output("hold_2", 16'hFFFE, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset clears the captured result without waiting for a clock.
        apply_stimulus(OP_ADD, 16'h0003, 16'h0004, 1'b1);
        tick();
        check_output("midreset_capture", 16'h0007, 1'b0, 1'b0, 1'b1);
        apply_stimulus(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("midreset_held", 16'h0000, 1'b0, 1'b0, 1'b0);

        // First capture happens on the first edge with rst_n high and in_valid high.
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(OP_PASS, 16'hFFFF, 16'h0005, 1'b1);
        tick();
        check_output("first_capture", 16'h0005, 1'b0, 1'b0, 1'b1);
        apply_stimulus(OP_PASS, 16'hFFFF, 16'h0009, 1'b0);
        tick();
        check_output("valid_drops", 16'h0005, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter N, default 16: operand and result width in bits; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 A  input  N  signed operand A (two's complement).
REQ-005 B  input  N  signed operand B (two's complement).
REQ-006 opcode  input  3  operation select, encoding per REQ-011.
REQ-007 in_valid  input  1  high when A, B and opcode are to be captured this cycle.
REQ-008 Y  output  N  signed result, registered.
REQ-009 co  output  1  carry/borrow/shift-out flag, registered.
REQ-010 out_valid  output  1  high for the cycle in which Y/co hold the result of a captured operation.

Function
REQ-011 Opcodes (Y; co):
- 000 ADD: A+B; unsigned carry out of bit N-1.
- 001 SUB: A-B; borrow, 1 when unsigned A < unsigned B.
- 010 AND: A&B; 0.
- 011 OR: A|B; 0.
- 100 XOR: A^B; 0.
- 101 SHL: A<<1, zero fill; old A[N-1].
- 110 ASR: A>>>1, sign fill; old A[0].
- 111 PASS: B; 0.
REQ-012 Latency is exactly one clock: operands with in_valid=1 at edge k produce Y/co at edge k, and out_valid=1 from edge k until edge k+1.
REQ-013 With in_valid=0 at an edge: Y and co hold their previous values; out_valid is 0.
REQ-014 Arithmetic wraps modulo 2^N; no saturation.
REQ-015 B is ignored for SHL and ASR; A is ignored for PASS.
REQ-016 The result is computed combinationally from the current inputs; there is no dependence on prior operations.
REQ-017 Back-to-back in_valid=1 yields one result per cycle with no stalls.

Reset
REQ-018 While rst_n=0: Y=0, co=0 and out_valid=0, asynchronously and regardless of clk.
REQ-019 Reset asserted mid-stream discards any captured operation.
REQ-020 The first capture occurs at the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-021 Macro DATAPATH_OVF_EN: when defined, the module adds output port ovf (1 bit, registered, reset 0, same latency as Y).
REQ-022 ovf is the signed overflow flag for ADD/SUB and 0 for all other opcodes.
REQ-023 When DATAPATH_OVF_EN is undefined, port ovf and its logic are absent, and all other behaviour is identical.

Structure
REQ-024 Package datapath_pkg holds:
- the opcode enum type (3 bits, names per REQ-011);
- the default width constant DATAPATH_N = 16.
REQ-025 The combinational operation logic is in sub-module datapath_alu (parameter N; inputs A, B, opcode; outputs result, carry and, under the macro, overflow).
REQ-026 The datapath module contains only the output registers, valid register and reset logic around datapath_alu.

Verification (N=16)
REQ-027 ADD A=32767, B=1 -> Y=-32768, co=0, ovf=1 (macro defined), out_valid=1 one cycle later.
REQ-028 ADD A=-1, B=1 -> Y=0, co=1, ovf=0.
REQ-029 SUB A=5, B=7 -> Y=-2, co=1.
REQ-030 SUB A=7, B=5 -> Y=2, co=0.
REQ-031 Shift and logic cases:
- SHL A=16'h8001 -> Y=16'h0002, co=1.
- ASR A=-4 -> Y=-2, co=0.
- AND 16'h0F0F, 16'h00FF -> Y=16'h000F, co=0.
REQ-032 Reset and hold cases:
- Issue ADD 3+4 and assert rst_n=0 before the next edge -> Y=0, co=0, out_valid=0 immediately.
- in_valid=0 with changing inputs -> Y holds its previous value.
